led_mode_ctrl: RTL and testbench

- Runtime configuration controller for the LED blinker datapath.
- Debounces the four raw active-low push keys and queues their press events.
- Arbitrates the queued events one at a time and turns them into a new blink divisor, a pattern mode and a run/pause flag.
- Delivers each configuration change to the clock divider and LED controller through a valid/ack handshake. Sits between the board KEY pins and clk_divider / led_btn_ctrl.

---
 rtl/led_mode_ctrl.sv | 177 +++++++++++++++++
 tb/tb_led_mode_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl.sv
// Runtime configuration controller: debounces four active-low keys, queues their
// press events and turns them into divisor/mode/run updates behind a valid/ack handshake.
module led_mode_ctrl #(
  parameter int unsigned DEB_CNT   = 4,
  parameter int unsigned DIV_RESET = 5_000_000,
  parameter int unsigned DIV_MIN   = 625_000,
  parameter int unsigned DIV_MAX   = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [3:0]  key_n,
  input  logic        cfg_ack,
  output logic [23:0] clk_div,
  output logic [1:0]  mode,
  output logic        run,
  output logic        cfg_valid,
  output logic        busy
);

  localparam logic [3:0]  DEB_W     = 4'(DEB_CNT);
  localparam logic [23:0] DIV_RST_W = 24'(DIV_RESET);
  localparam logic [23:0] DIV_MIN_W = 24'(DIV_MIN);
  localparam logic [23:0] DIV_MAX_W = 24'(DIV_MAX);
  localparam logic [24:0] DIV_MAX_X = 25'(DIV_MAX);

  typedef enum logic [1:0] {IDLE, APPLY, WAIT_ACK} state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer and debounce
  // ---------------------------------------------------------------------------
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      pressed;
  logic [3:0]      key_db_q, key_db_d, key_prev_q;
  logic [3:0][3:0] cnt_q, cnt_d;
  logic [3:0]      ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  always_comb begin
    key_db_d = key_db_q;
    cnt_d    = cnt_q;
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (pressed[i] != key_db_q[i]) begin
          if (cnt_q[i] + 4'd1 == DEB_W) begin
            key_db_d[i] = ~key_db_q[i];
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_db_q   <= '0;
      key_prev_q <= '0;
      cnt_q      <= '0;
    end else begin
      key_db_q   <= key_db_d;
      key_prev_q <= key_db_q;
      cnt_q      <= cnt_d;
    end
  end

  // One-clk pulse on the debounced press edge only.
  assign ev = key_db_q & ~key_prev_q;

  // ---------------------------------------------------------------------------
  // Pending events, arbitration and configuration FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  pend_q, pend_d, clr;
  logic [1:0]  gnt_q, gnt_d;
  logic [23:0] div_q, div_d, cand_div, half_div;
  logic [24:0] dbl_div;
  logic [1:0]  mode_q, mode_d, cand_mode;
  logic        run_q, run_d, cand_run;
  logic        vld_q, vld_d;

  assign half_div = div_q >> 1;
  assign dbl_div  = {div_q, 1'b0};

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    div_d     = div_q;
    mode_d    = mode_q;
    run_d     = run_q;
    vld_d     = vld_q;
    clr       = '0;
    cand_div  = div_q;
    cand_mode = mode_q;
    cand_run  = run_q;
    case (state_q)
      IDLE: begin
        if (pend_q != 4'd0) begin
          if      (pend_q[3]) gnt_d = 2'd3;
          else if (pend_q[2]) gnt_d = 2'd2;
          else if (pend_q[1]) gnt_d = 2'd1;
          else                gnt_d = 2'd0;
          clr     = 4'd1 << gnt_d;
          state_d = APPLY;
        end
      end
      APPLY: begin
        case (gnt_q)
          2'd0:    cand_div  = (half_div < DIV_MIN_W) ? DIV_MIN_W : half_div;
          2'd1:    cand_div  = (dbl_div > DIV_MAX_X) ? DIV_MAX_W : dbl_div[23:0];
          2'd2:    cand_mode = mode_q + 2'd1;
          default: cand_run  = ~run_q;
        endcase
        // A clamped no-op is dropped without bothering the downstream blocks.
        if ({cand_div, cand_mode, cand_run} == {div_q, mode_q, run_q}) begin
          state_d = IDLE;
        end else begin
          div_d   = cand_div;
          mode_d  = cand_mode;
          run_d   = cand_run;
          vld_d   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (cfg_ack) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // New events win over the grant clear of the same bit.
    pend_d = (pend_q & ~clr) | ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      gnt_q   <= '0;
      div_q   <= DIV_RST_W;
      mode_q  <= '0;
      run_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      run_q   <= run_d;
      vld_q   <= vld_d;
    end
  end

  assign clk_div   = div_q;
  assign mode      = mode_q;
  assign run       = run_q;
  assign cfg_valid = vld_q;
  assign busy      = (state_q != IDLE) || (pend_q != 4'd0);

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl: stimulus pushes expected configs, a monitor
// pops and compares on every cfg_valid rising edge.
module tb_led_mode_ctrl;

  typedef struct packed {
    logic [23:0] div;
    logic [1:0]  mode;
    logic        run;
  } cfg_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  key_n = 4'hF;
  logic        cfg_ack = 1'b0;
  logic [23:0] clk_div;
  logic [1:0]  mode;
  logic        run;
  logic        cfg_valid;
  logic        busy;

  int   n_chk = 0;
  int   n_fail = 0;
  cfg_t exp_q[$];
  cfg_t mon_e;
  cfg_t mon_a;
  logic prev_v = 1'b0;

  led_mode_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .key_n(key_n), .cfg_ack(cfg_ack),
    .clk_div(clk_div), .mode(mode), .run(run), .cfg_valid(cfg_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: every new configuration must match the head of the queue.
  always @(negedge clk) begin
    if (cfg_valid && !prev_v) begin
      n_chk++;
      mon_a = '{div: clk_div, mode: mode, run: run};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_cfg: got div=%0d mode=%0d run=%0d, required no config",
                 clk_div, mode, run);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL cfg_compare: got div=%0d mode=%0d run=%0d required div=%0d mode=%0d run=%0d",
                   clk_div, mode, run, mon_e.div, mon_e.mode, mon_e.run);
        end
      end
    end
    prev_v = cfg_valid;
  end

  task automatic push(input logic [23:0] d, input logic [1:0] m, input logic r);
    exp_q.push_back('{div: d, mode: m, run: r});
  endtask

  task automatic do_tick();
    repeat (2) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic press(input logic [3:0] m, input int n);
    key_n = key_n & ~m;
    repeat (3) @(negedge clk);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic release_key(input logic [3:0] m);
    key_n = key_n | m;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) do_tick();
    repeat (4) @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    cfg_ack = 1'b1;
    @(negedge clk);
    cfg_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int i = 0;
    while (!cfg_valid && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk(name, {31'd0, cfg_valid}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_clk_div", {8'd0, clk_div}, 32'd5_000_000);
    chk("rst_mode", {30'd0, mode}, 32'd0);
    chk("rst_run", {31'd0, run}, 32'd1);
    chk("rst_cfg_valid", {31'd0, cfg_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Glitch of 3 ticks is rejected; 4 ticks is accepted with 3-clk latency.
    press(4'b0001, 3);
    release_key(4'b0001);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_div", {8'd0, clk_div}, 32'd5_000_000);
    push(24'd2_500_000, 2'd0, 1'b1);
    press(4'b0001, 4);
    @(negedge clk);
    chk("lat_e1", {31'd0, cfg_valid}, 32'd0);
    @(negedge clk);
    chk("lat_e2", {31'd0, cfg_valid}, 32'd0);
    @(negedge clk);
    chk("lat_e3", {31'd0, cfg_valid}, 32'd1);
    chk("lat_div", {8'd0, clk_div}, 32'd2_500_000);
    release_key(4'b0001);
    ack_pulse();

    // Clamp down with ack tied high.
    do_reset();
    cfg_ack = 1'b1;
    push(24'd2_500_000, 2'd0, 1'b1);
    push(24'd1_250_000, 2'd0, 1'b1);
    push(24'd625_000, 2'd0, 1'b1);
    for (int p = 0; p < 5; p++) begin
      press(4'b0001, 4);
      release_key(4'b0001);
    end
    chk("clampdn_div", {8'd0, clk_div}, 32'd625_000);
    chk("clampdn_busy", {31'd0, busy}, 32'd0);
    chk("clampdn_vld", {31'd0, cfg_valid}, 32'd0);
    chk("clampdn_q", exp_q.size(), 32'd0);

    // Clamp up: second KEY1 press is silent.
    do_reset();
    push(24'd10_000_000, 2'd0, 1'b1);
    for (int p = 0; p < 2; p++) begin
      press(4'b0010, 4);
      release_key(4'b0010);
    end
    chk("clampup_div", {8'd0, clk_div}, 32'd10_000_000);
    chk("clampup_mode", {30'd0, mode}, 32'd0);
    chk("clampup_run", {31'd0, run}, 32'd1);
    chk("clampup_busy", {31'd0, busy}, 32'd0);
    cfg_ack = 1'b0;

    // Arbitration: KEY2 beats KEY0 when both debounce together.
    do_reset();
    push(24'd5_000_000, 2'd1, 1'b1);
    push(24'd2_500_000, 2'd1, 1'b1);
    press(4'b0101, 4);
    release_key(4'b0101);
    chk("arb_vld1", {31'd0, cfg_valid}, 32'd1);
    chk("arb_busy", {31'd0, busy}, 32'd1);
    ack_pulse();
    wait_valid("arb_vld2");
    chk("arb_div2", {8'd0, clk_div}, 32'd2_500_000);
    chk("arb_mode2", {30'd0, mode}, 32'd1);
    ack_pulse();
    chk("arb_idle", {31'd0, busy}, 32'd0);

    // Handshake hold: outputs frozen for 100 clk while KEY2 queues behind.
    do_reset();
    push(24'd5_000_000, 2'd0, 1'b0);
    press(4'b1000, 4);
    wait_valid("hold_vld");
    release_key(4'b1000);
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          chk("hold_stable", {4'd0, clk_div, mode, run, cfg_valid},
              {4'd0, 24'd5_000_000, 2'd0, 1'b0, 1'b1});
        end
      end
      begin
        press(4'b0100, 4);
        release_key(4'b0100);
      end
    join
    chk("hold_busy", {31'd0, busy}, 32'd1);
    push(24'd5_000_000, 2'd1, 1'b0);
    ack_pulse();
    wait_valid("hold_vld2");
    chk("hold_mode2", {30'd0, mode}, 32'd1);
    ack_pulse();

    // Asynchronous reset during WAIT_ACK with pend[1] set.
    do_reset();
    push(24'd10_000_000, 2'd0, 1'b1);
    press(4'b0010, 4);
    wait_valid("rstmid_vld");
    release_key(4'b0010);
    press(4'b0010, 4);
    release_key(4'b0010);
    chk("rstmid_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_div", {8'd0, clk_div}, 32'd5_000_000);
    chk("rstmid_mode", {30'd0, mode}, 32'd0);
    chk("rstmid_run", {31'd0, run}, 32'd1);
    chk("rstmid_vld", {31'd0, cfg_valid}, 32'd0);
    chk("rstmid_pend", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rstmid_after_vld", {31'd0, cfg_valid}, 32'd0);
    chk("rstmid_after_busy", {31'd0, busy}, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
